neopixel_driver: RTL and testbench
==================================

Name: neopixel_driver

Overview:
- Downstream consumer of the NeoPixel producer FSM; receives its load_color/send_it handshake.
- Holds a GRB colour buffer of NUM_PIXELS x 3 x 8 bits, written one byte per load.
- On send_it, serialises the whole buffer as a WS2812 one-wire waveform on neo_data, then holds a latch (reset) gap.
- Raises ready_to_load and ready_to_send only when a new load or frame is safe.

Parameters:
NUM_PIXELS, 5, pixels in the strip; valid pixel_index range is 0..NUM_PIXELS-1 (NUM_PIXELS <= 8).
T0H_CYC, 17, clocks neo_data is high for a 0 bit.
T1H_CYC, 35, clocks neo_data is high for a 1 bit.
BIT_CYC, 62, clocks per bit period (high + low); T0H_CYC < T1H_CYC < BIT_CYC.
LATCH_CYC, 2500, clocks neo_data is held low after the last bit (about 50 us at 50 MHz).

Ports:
clock  in  1  single system clock; all logic on its rising edge.
reset  in  1  synchronous, active-low reset; asserted when 0, sampled on clock rising edge.
pixel_index  in  3  pixel written by a load.
color_index  in  2  0 = green, 1 = red, 2 = blue, 3 = no-op.
color_level  in  8  byte written by a load.
load_color  in  1  write strobe, one byte per asserted cycle.
send_it  in  1  start-frame strobe.
neo_data  out  1  serial WS2812 waveform.
ready_to_load  out  1  a load is accepted this cycle.
ready_to_send  out  1  a send_it is accepted this cycle.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE and all buffer bytes clear to 0x00.
  - neo_data=0, ready_to_load=1, ready_to_send=1 on the following cycle.
  - Bit, pixel and cycle counters clear.
  - Reset mid-frame aborts the frame immediately; no latch gap is produced.
- States are IDLE, SEND and LATCH. Outputs are registered.
- IDLE:
  - ready_to_load=1, ready_to_send=1, neo_data=0.
  - load_color=1: byte at [pixel_index][color_index] <= color_level at that edge; the new value is visible to any later frame.
  - Loads are ignored when pixel_index >= NUM_PIXELS or color_index==3.
  - Consecutive loads are accepted every cycle; a repeat write to the same byte means last write wins.
  - send_it=1 with load_color=0: go to SEND at that edge.
  - load_color and send_it both 1: the load is performed and send_it is ignored. ready_to_send stays 1, so the producer re-issues send_it.
- SEND:
  - ready_to_load=0, ready_to_send=0; load_color and send_it are ignored.
  - Bit order: pixel 0 up to pixel NUM_PIXELS-1; within a pixel G, R, B; within a byte MSB first.
  - Bit timing: neo_data=1 for T1H_CYC (bit 1) or T0H_CYC (bit 0) cycles, then 0 for the remainder of BIT_CYC.
  - neo_data first goes high on the cycle after the send_it edge.
  - The frame lasts exactly NUM_PIXELS*24*BIT_CYC cycles, with no gaps between bits, bytes or pixels.
  - The buffer is read directly; it cannot change during SEND because loads are blocked.
- LATCH:
  - neo_data=0 for exactly LATCH_CYC cycles, then IDLE.
  - Both ready outputs return to 1 on the first IDLE cycle.
  - send_it to ready_to_send high takes NUM_PIXELS*24*BIT_CYC + LATCH_CYC + 1 cycles.
- Widths and counters:
  - Cycle counter is wide enough for max(BIT_CYC, LATCH_CYC).
  - Bit counter counts 0..23; pixel counter counts 0..NUM_PIXELS-1.
  - All counters wrap or clear exactly at their terminal count; no off-by-one period stretch.

Test Plan:
- Reset held low 3 cycles, then released -> neo_data=0, both readies=1; sending with no loads gives 120 zero-bits, each 17 cycles high and 45 low.
- Load pixel 0 G=0x80, R=0x01, B=0x00, then send_it -> pixel 0's first bit is 35 high / 27 low; bits 1..14 are 17/45; bit 15 is 35/27; the rest are 17/45. Then 2500 low cycles, then readies=1 at cycle 7440+2500+1.
- Load pixel_index=5 and color_index=3 with 0xFF, then send -> no buffer change; all bits are zero-bits.
- load_color and send_it together in IDLE -> byte written, state stays IDLE; send_it on the next cycle -> frame carries the new byte.
- load_color and send_it pulsed during SEND and LATCH -> ignored; the frame is bit-identical to the undisturbed frame, and the buffer is unchanged.
- Reset driven low at bit 50 of a frame -> next cycle neo_data=0, both readies=1, and the buffer is cleared to 0x00.

Source files
------------

// File: rtl/neopixel_driver.sv
// neopixel_driver
//   Holds a GRB colour buffer (NUM_PIXELS x 3 bytes) written one byte per load.
//   On a send request it shifts the whole buffer out as a WS2812 one-wire
//   waveform, then holds the line low for the latch gap before accepting
//   new work.
//
// Ports
//   clock          system clock, all logic on the rising edge
//   reset          synchronous, active-low reset
//   pixel_index    pixel addressed by a load (ignored if >= NUM_PIXELS)
//   color_index    0 = green, 1 = red, 2 = blue, 3 = no-op
//   color_level    byte written by a load
//   load_color     write strobe, one byte per asserted cycle (IDLE only)
//   send_it        start-of-frame strobe (IDLE only, loses to load_color)
//   neo_data       registered WS2812 serial output
//   ready_to_load  high while a load is accepted (IDLE)
//   ready_to_send  high while a send_it is accepted (IDLE)
module neopixel_driver #(
  parameter int NUM_PIXELS = 5,
  parameter int T0H_CYC    = 17,
  parameter int T1H_CYC    = 35,
  parameter int BIT_CYC    = 62,
  parameter int LATCH_CYC  = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       load_color,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send
);

  localparam int MAX_CYC   = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
  localparam int CYC_W     = $clog2(MAX_CYC);
  localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int NUM_BYTES = NUM_PIXELS * 3;
  localparam int ADDR_W    = $clog2(NUM_BYTES);
  localparam logic [3:0] NUM_PIX_L = 4'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [4:0]         bit_q, bit_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               neo_q, neo_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         buf_q [NUM_BYTES];

  // Write port: byte address = pixel*3 + colour, computed wide enough for
  // out-of-range indices so the validity check happens before truncation.
  logic              wr_en;
  logic [4:0]        wr_full;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_full = {2'b00, pixel_index} * 5'd3 + {3'b000, color_index};
  assign wr_addr = wr_full[ADDR_W-1:0];
  assign wr_en   = (state_q == IDLE) && load_color &&
                   ({1'b0, pixel_index} < NUM_PIX_L) && (color_index != 2'd3);

  // Read port looks at the next-state counters so the registered output
  // lines up with the bit being transmitted. bit_d[4:3] selects G/R/B and
  // ~bit_d[2:0] walks each byte MSB first.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bit;

  assign rd_addr = ADDR_W'(pix_d) * ADDR_W'(3) + ADDR_W'(bit_d[4:3]);
  assign rd_bit  = buf_q[rd_addr][~bit_d[2:0]];

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (send_it && !load_color) begin
          state_d = SEND;
          cyc_d   = '0;
          bit_d   = '0;
          pix_d   = '0;
        end
      end
      SEND: begin
        if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (pix_q == PIX_W'(NUM_PIXELS - 1)) begin
              pix_d   = '0;
              state_d = LATCH;
            end else begin
              pix_d = pix_q + PIX_W'(1);
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      LATCH: begin
        if (cyc_q == CYC_W'(LATCH_CYC - 1)) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    neo_d = 1'b0;
    rdy_d = (state_d == IDLE);
    if (state_d == SEND) begin
      neo_d = rd_bit ? (cyc_d < CYC_W'(T1H_CYC)) : (cyc_d < CYC_W'(T0H_CYC));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      neo_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      neo_q   <= neo_d;
      rdy_q   <= rdy_d;
    end
  end

  // One register per buffer byte so reset can clear the whole buffer.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_buf
      always_ff @(posedge clock) begin
        if (!reset) begin
          buf_q[gi] <= 8'h00;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          buf_q[gi] <= color_level;
        end
      end
    end
  endgenerate

  assign neo_data      = neo_q;
  assign ready_to_load = rdy_q;
  assign ready_to_send = rdy_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Testbench for neopixel_driver: randomized loads checked against a byte-array
// model of the colour buffer; every frame is compared bit by bit with the
// waveform derived from that model.
module tb_neopixel_driver;

  localparam int NP    = 5;
  localparam int T0H   = 17;
  localparam int T1H   = 35;
  localparam int BITC  = 62;
  localparam int LATCH = 2500;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pixel_index = '0;
  logic [1:0] color_index = '0;
  logic [7:0] color_level = '0;
  logic       load_color = 1'b0;
  logic       send_it = 1'b0;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [NP*3];

  neopixel_driver #(
    .NUM_PIXELS(NP), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .LATCH_CYC(LATCH)
  ) dut (
    .clock(clock), .reset(reset), .pixel_index(pixel_index),
    .color_index(color_index), .color_level(color_level),
    .load_color(load_color), .send_it(send_it), .neo_data(neo_data),
    .ready_to_load(ready_to_load), .ready_to_send(ready_to_send)
  );

  always #5 clock = ~clock;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NP*3; i++) model[i] = 8'h00;
  endtask

  task automatic model_load(input int p, input int c, input logic [7:0] v);
    if (p < NP && c != 3) model[p*3 + c] = v;
  endtask

  task automatic do_load(input int p, input int c, input logic [7:0] v);
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = v;
    load_color  = 1'b1;
    tick();
    load_color  = 1'b0;
    model_load(p, c, v);
    $display("load pixel=%0d color=%0d level=%02h", p, c, v);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (neo_data !== 1'b0 || ready_to_load !== 1'b1 || ready_to_send !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: neo=%b rl=%b rs=%b, expected neo=0 rl=1 rs=1",
               name, neo_data, ready_to_load, ready_to_send);
    end else begin
      $display("%s: idle outputs ok", name);
    end
  endtask

  // Sends a frame and checks it against the model. abort_bit >= 0 pulls
  // reset at the start of that bit instead of finishing the frame.
  task automatic run_frame(input string name, input bit disturb, input int abort_bit);
    bit exp_bits [NP*24];
    int idx;
    bit bad;
    int hi_cnt;
    int exp_hi;
    idx = 0;
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        for (int k = 7; k >= 0; k--) begin
          exp_bits[idx] = model[p*3 + c][k];
          idx++;
        end

    send_it = 1'b1;
    tick();
    send_it = 1'b0;
    for (int b = 0; b < NP*24; b++) begin
      bad = 1'b0;
      hi_cnt = 0;
      exp_hi = exp_bits[b] ? T1H : T0H;
      for (int ph = 0; ph < BITC; ph++) begin
        if (b == abort_bit && ph == 0) begin
          vectors++;
          if (neo_data !== 1'b1) begin
            miscompares++;
            $display("FAIL %s pre-abort: neo=%b, expected 1", name, neo_data);
          end
          reset = 1'b0;
          tick();
          reset = 1'b1;
          clear_model();
          check_idle({name, " after abort"});
          return;
        end
        if (neo_data !== (ph < exp_hi) || ready_to_load !== 1'b0 || ready_to_send !== 1'b0)
          bad = 1'b1;
        if (neo_data === 1'b1) hi_cnt++;
        if (disturb) begin
          load_color  = 1'($urandom_range(0, 1));
          send_it     = 1'($urandom_range(0, 1));
          pixel_index = 3'($urandom_range(0, 7));
          color_index = 2'($urandom_range(0, 3));
          color_level = 8'($urandom);
        end
        tick();
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s bit %0d: high %0d cycles (rl=%b rs=%b), expected %0d high / %0d low, readies 0",
                 name, b, hi_cnt, ready_to_load, ready_to_send, exp_hi, BITC - exp_hi);
      end
    end
    $display("%s: %0d bits compared", name, NP*24);

    bad = 1'b0;
    for (int i = 0; i < LATCH; i++) begin
      if (neo_data !== 1'b0 || ready_to_load !== 1'b0 || ready_to_send !== 1'b0) bad = 1'b1;
      if (disturb) begin
        load_color = 1'($urandom_range(0, 1));
        send_it    = 1'($urandom_range(0, 1));
        pixel_index = 3'($urandom_range(0, 7));
        color_level = 8'($urandom);
      end
      tick();
    end
    load_color = 1'b0;
    send_it    = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s latch: line or readies not low for %0d cycles", name, LATCH);
    end else begin
      $display("%s: latch gap ok", name);
    end
    // Now at send edge + FRAME + LATCH + 1.
    check_idle({name, " ready after latch"});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    check_idle("reset held");
    reset = 1'b1;
    tick();
    check_idle("reset released");
    clear_model();
    run_frame("zero frame", 1'b0, -1);
  endtask

  task automatic test_pattern();
    do_load(0, 0, 8'h80);
    do_load(0, 1, 8'h01);
    do_load(0, 2, 8'h00);
    run_frame("pattern frame", 1'b0, -1);
  endtask

  task automatic test_ignored_loads();
    do_load(5, 0, 8'hFF);
    do_load(0, 3, 8'hFF);
    do_load(7, 1, 8'hFF);
    do_load(2, 3, 8'hFF);
    run_frame("ignored loads frame", 1'b0, -1);
  endtask

  task automatic test_load_and_send();
    logic [7:0] v;
    v = 8'($urandom) | 8'h81;
    pixel_index = 3'd3;
    color_index = 2'd2;
    color_level = v;
    load_color  = 1'b1;
    send_it     = 1'b1;
    tick();
    load_color  = 1'b0;
    send_it     = 1'b0;
    model_load(3, 2, v);
    check_idle("load+send stays idle");
    run_frame("load+send frame", 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int p, c;
    logic [7:0] v;
    p = 0;
    c = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 != 4) begin
        p = $urandom_range(0, 7);
        c = $urandom_range(0, 3);
      end
      v = 8'($urandom);
      pixel_index = 3'(p);
      color_index = 2'(c);
      color_level = v;
      load_color  = 1'b1;
      tick();
      model_load(p, c, v);
    end
    load_color = 1'b0;
    $display("back-to-back: 30 loads issued");
    run_frame("back-to-back frame", 1'b0, -1);
  endtask

  task automatic test_disturbed();
    run_frame("disturbed frame", 1'b1, -1);
    run_frame("undisturbed repeat", 1'b0, -1);
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < NP*3; i++) do_load(i / 3, i % 3, 8'($urandom) | 8'h10);
    run_frame("abort frame", 1'b0, 50);
    run_frame("cleared buffer frame", 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_ignored_loads();
    test_load_and_send();
    test_back_to_back();
    test_disturbed();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
